// File: rtl/fft_bin_streamer_if.sv
// FFT frame bus (parallel, pulsed) plus serial bin stream with valid/ready and status.
// slave = streamer side, master = FFT producer / downstream consumer side.
interface fft_bin_streamer_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
);
  logic             fft_valid;
  logic [DW-1:0]    fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [DW-1:0]    fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic             bin_ready;
  logic             bin_valid;
  logic [DW-1:0]    bin_data;
  logic [3:0]       bin_idx;
  logic             bin_last;
  logic [CNT_W-1:0] frames_out;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  bin_ready,
    output bin_valid, bin_data, bin_idx, bin_last, frames_out, drop_cnt, overflow
  );

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output bin_ready,
    input  bin_valid, bin_data, bin_idx, bin_last, frames_out, drop_cnt, overflow
  );
endinterface

// File: rtl/fft_bin_streamer.sv
// Captures 16-bin FFT frames into a two-slot ping-pong buffer and replays them
// as a serial valid/ready bin stream; frames arriving with both slots full are dropped.
module fft_bin_streamer #(
  parameter int DW    = 32,
  parameter int NBINS = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  fft_bin_streamer_if.slave bus
);
  localparam logic [3:0] LAST_IDX = 4'(NBINS - 1);

  logic [DW-1:0]    din [NBINS];
  logic [DW-1:0]    mem [2][NBINS];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ;
  logic [3:0]       rd_idx;
  logic [CNT_W-1:0] frames_q, drop_q;
  logic             ovf_q;
  logic             valid, fire, rel, capture, drop;

  assign din[0]  = bus.fft_d0;
  assign din[1]  = bus.fft_d1;
  assign din[2]  = bus.fft_d2;
  assign din[3]  = bus.fft_d3;
  assign din[4]  = bus.fft_d4;
  assign din[5]  = bus.fft_d5;
  assign din[6]  = bus.fft_d6;
  assign din[7]  = bus.fft_d7;
  assign din[8]  = bus.fft_d8;
  assign din[9]  = bus.fft_d9;
  assign din[10] = bus.fft_d10;
  assign din[11] = bus.fft_d11;
  assign din[12] = bus.fft_d12;
  assign din[13] = bus.fft_d13;
  assign din[14] = bus.fft_d14;
  assign din[15] = bus.fft_d15;

  assign valid   = (occ != 2'd0);
  assign fire    = valid & bus.bin_ready;
  assign rel     = fire & (rd_idx == LAST_IDX);
  // A release on the same edge frees a slot, so a full buffer can still accept.
  assign capture = bus.fft_valid & ((occ != 2'd2) | rel);
  assign drop    = bus.fft_valid & ~capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      rd_idx   <= 4'd0;
      frames_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (fire) rd_idx <= rel ? 4'd0 : rd_idx + 4'd1;
      if (rel) begin
        rd_ptr   <= ~rd_ptr;
        frames_q <= frames_q + 1'b1;
      end
      occ <= occ + {1'b0, capture} - {1'b0, rel};
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Frame storage needs no reset: it is only read while occ marks it as filled.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NBINS; i++) mem[wr_ptr][i] <= din[i];
    end
  end

  assign bus.bin_valid  = valid;
  assign bus.bin_data   = valid ? mem[rd_ptr][rd_idx] : '0;
  assign bus.bin_idx    = rd_idx;
  assign bus.bin_last   = valid & (rd_idx == LAST_IDX);
  assign bus.frames_out = frames_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.overflow   = ovf_q;
endmodule
